// File: rtl/alu_pipe.sv
// alu_pipe: a two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 holds the operands. Stage 2 holds the result and its flags.
// A sticky carry flag chains the ADC and SBB operations.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             status,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             carry_flag
);

    localparam int MSB = WIDTH - 1;

    // Stage 1 registers
    logic             r_s1_valid;
    logic             r_s1_status;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [3:0]       r_s1_op;

    // Stage 2 registers
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;

    // Handshake wires
    logic w_s2_load;
    logic w_in_fire;
    logic w_s1_fire;

    // Datapath wires
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;

    assign w_s2_load  = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_load;
    assign w_in_fire  = in_valid && in_ready;
    assign w_s1_fire  = r_s1_valid && w_s2_load;

    assign out_valid  = r_s2_valid;
    assign result     = r_result;
    assign cout       = r_cout;
    assign overflow   = r_ovf;
    assign zero       = r_zero;
    assign negative   = r_neg;
    assign carry_flag = r_carry;

    // Select the second adder operand and the carry-in for the arithmetic ops.
    // Subtract forms use the inverted operand, so one adder covers every form.
    always_comb begin
        w_y     = '0;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        if (r_s1_op[3]) begin
            case (r_s1_op[2:0])
                3'b111: begin w_y = r_s1_b;          w_cin = 1'b0;    w_arith = 1'b1; end
                3'b110: begin w_y = ~r_s1_b;         w_cin = 1'b1;    w_arith = 1'b1; end
                3'b101: begin w_y = WIDTH'(1);       w_cin = 1'b0;    w_arith = 1'b1; end
                3'b100: begin w_y = ~(WIDTH'(1));    w_cin = 1'b1;    w_arith = 1'b1; end
                3'b011: begin w_y = r_s1_b;          w_cin = r_carry; w_arith = 1'b1; end
                3'b010: begin w_y = ~r_s1_b;         w_cin = r_carry; w_arith = 1'b1; end
                default: begin w_y = '0;             w_cin = 1'b0;    w_arith = 1'b0; end
            endcase
        end
    end

    assign w_sum = {1'b0, r_s1_a} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

    // Compute the logic-unit result. Undefined logic opcodes give zero.
    always_comb begin
        case (r_s1_op[2:0])
            3'b111:  w_logic = r_s1_a & r_s1_b;
            3'b110:  w_logic = r_s1_a | r_s1_b;
            3'b101:  w_logic = r_s1_a ^ r_s1_b;
            3'b100:  w_logic = ~r_s1_a;
            default: w_logic = '0;
        endcase
    end

    // Merge the unit outputs. A status=0 beat produces all zeros.
    // The overflow test on the effective operand w_y covers the add and subtract forms together.
    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        if (r_s1_status) begin
            if (r_s1_op[3]) begin
                if (w_arith) begin
                    w_res  = w_sum[MSB:0];
                    w_cout = w_sum[WIDTH];
                    w_ovf  = (r_s1_a[MSB] == w_y[MSB]) && (w_sum[MSB] != r_s1_a[MSB]);
                end
            end else begin
                w_res = w_logic;
            end
        end
    end

    // Stage 1 valid: set on accept, cleared when stage 2 takes the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
        end else if (w_s1_fire) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 1 operand capture. The data needs no reset because r_s1_valid qualifies it.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_status <= status;
            r_s1_a      <= a;
            r_s1_b      <= b;
            r_s1_op     <= opcode;
        end
    end

    // Stage 2 result and flags. The outputs hold their values while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_cout   <= w_cout;
                r_ovf    <= w_ovf;
                r_zero   <= r_s1_status && (w_res == '0);
                r_neg    <= w_res[MSB];
            end
        end
    end

    // Sticky carry: updated only by enabled beats with a defined arithmetic opcode.
    // The update happens on the stage-2 load, so back-to-back ADC/SBB beats chain without a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else if (w_s1_fire && r_s1_status && w_arith) begin
            r_carry <= w_cout;
        end
    end

endmodule
